// File: rtl/sk6812_pkg.sv
// Shared types for the SK6812 strip sequencer: pixel layout, sequencer states, colour width.
package sk6812_pkg;

  localparam int unsigned SK6812_COLOR_W = 32;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
    logic [7:0] w;
  } pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STROBE,
    GUARD,
    WAITP,
    LATCH,
    LGUARD,
    LWAIT
  } seq_state_e;

endpackage

// File: rtl/sk6812_pixel_ram.sv
// Pixel memory: one write port, one registered read port, contents not reset.
module sk6812_pixel_ram
  import sk6812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  pixel_t           i_wr_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output pixel_t           o_rd_data
);

  pixel_t mem [NUM_LEDS];

  always_ff @(posedge i_clk) begin
    // Indices past the populated depth are dropped rather than aliased.
    if (i_wr_en && (32'(i_wr_idx) < NUM_LEDS)) begin
      mem[i_wr_idx] <= i_wr_data;
    end
    o_rd_data <= mem[i_rd_idx];
  end

endmodule

// File: rtl/sk6812_strip_sequencer.sv
// Streams pixels 0..cnt-1 from the pixel memory to the SK6812 serializer, then issues the latch strobe.
module sk6812_strip_sequencer
  import sk6812_pkg::*;
#(
  parameter  int unsigned NUM_LEDS = 8,
  localparam int unsigned IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_wr_en,
  input  logic [IDX_W-1:0]          i_wr_idx,
  input  logic [SK6812_COLOR_W-1:0] i_wr_color,
  input  logic [IDX_W:0]            i_num_active,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_start_drop,
  output logic                      o_led_strb,
  output logic [SK6812_COLOR_W-1:0] o_led_color,
  output logic                      o_reset_strb,
  input  logic                      i_drv_busy
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W + 1)'(NUM_LEDS);

  seq_state_e state, state_d;
  logic [IDX_W:0] idx, idx_d, idx_inc;
  logic [IDX_W:0] cnt, cnt_d, start_cnt;
  logic busy_d, done_d, drop_d, strb_d, rst_strb_d;
  logic [SK6812_COLOR_W-1:0] color_d;
  pixel_t rd_data;

  sk6812_pixel_ram #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en),
    .i_wr_idx  (i_wr_idx),
    .i_wr_data (pixel_t'(i_wr_color)),
    .i_rd_idx  (idx[IDX_W-1:0]),
    .o_rd_data (rd_data)
  );

  assign start_cnt = (i_num_active > CNT_MAX) ? CNT_MAX : i_num_active;
  assign idx_inc   = idx + 1'b1;

  // All handshake outputs are computed here and registered below, so each
  // appears one cycle after the state that produces it.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    busy_d     = o_busy;
    done_d     = 1'b0;
    drop_d     = i_start && (state != IDLE);
    strb_d     = 1'b0;
    rst_strb_d = 1'b0;
    color_d    = o_led_color;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          cnt_d   = start_cnt;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (start_cnt == '0) ? LATCH : FETCH;
        end
      end
      FETCH:  state_d = STROBE;
      STROBE: begin
        color_d = rd_data;
        strb_d  = 1'b1;
        state_d = GUARD;
      end
      GUARD:  state_d = WAITP;
      WAITP: begin
        if (!i_drv_busy) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt) ? LATCH : FETCH;
        end
      end
      LATCH: begin
        rst_strb_d = 1'b1;
        state_d    = LGUARD;
      end
      LGUARD: state_d = LWAIT;
      LWAIT: begin
        if (!i_drv_busy) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_start_drop <= 1'b0;
      o_led_strb   <= 1'b0;
      o_reset_strb <= 1'b0;
      o_led_color  <= '0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      cnt          <= cnt_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_start_drop <= drop_d;
      o_led_strb   <= strb_d;
      o_reset_strb <= rst_strb_d;
      o_led_color  <= color_d;
    end
  end

endmodule

// File: tb/tb_sk6812_strip_sequencer.sv
// Directed bench for sk6812_strip_sequencer with a serializer busy model; second instance covers a non-power-of-two depth.
module tb_sk6812_strip_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en      = 1'b0;
  logic [2:0]  wr_idx     = '0;
  logic [31:0] wr_color   = '0;
  logic [3:0]  num_active = '0;
  logic        start      = 1'b0;
  logic        start6     = 1'b0;

  logic busy, done, drop, strb, rst_strb, drv_busy;
  logic [31:0] color;
  logic busy6, done6, drop6, strb6, rst_strb6, drv_busy6;
  logic [31:0] color6;

  sk6812_strip_sequencer #(.NUM_LEDS(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
    .i_wr_color(wr_color), .i_num_active(num_active), .i_start(start),
    .o_busy(busy), .o_done(done), .o_start_drop(drop), .o_led_strb(strb),
    .o_led_color(color), .o_reset_strb(rst_strb), .i_drv_busy(drv_busy)
  );

  sk6812_strip_sequencer #(.NUM_LEDS(6)) dut6 (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_en(wr_en), .i_wr_idx(wr_idx),
    .i_wr_color(wr_color), .i_num_active(num_active), .i_start(start6),
    .o_busy(busy6), .o_done(done6), .o_start_drop(drop6), .o_led_strb(strb6),
    .o_led_color(color6), .o_reset_strb(rst_strb6), .i_drv_busy(drv_busy6)
  );

  // Serializer model: busy from the cycle after a strobe, 40 cycles per pixel, 100 for the latch.
  int bcnt, bcnt6;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin drv_busy <= 1'b0; bcnt <= 0; end
    else if (strb)     begin drv_busy <= 1'b1; bcnt <= 40;  end
    else if (rst_strb) begin drv_busy <= 1'b1; bcnt <= 100; end
    else if (bcnt > 1) bcnt <= bcnt - 1;
    else begin drv_busy <= 1'b0; bcnt <= 0; end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin drv_busy6 <= 1'b0; bcnt6 <= 0; end
    else if (strb6)     begin drv_busy6 <= 1'b1; bcnt6 <= 40;  end
    else if (rst_strb6) begin drv_busy6 <= 1'b1; bcnt6 <= 100; end
    else if (bcnt6 > 1) bcnt6 <= bcnt6 - 1;
    else begin drv_busy6 <= 1'b0; bcnt6 <= 0; end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_strb, n_rst, n_drop, idle_cnt, last_cycles;
  bit overlap_err = 1'b0, color_err = 1'b0, gap_err = 1'b0, busy_at_done;
  logic [31:0] last_col = '0;
  logic [31:0] got_col[$];
  logic [31:0] mem_model[8];

  always @(negedge clk) begin
    if (rst_n) begin
      if (strb && rst_strb) overlap_err = 1'b1;
      if (drv_busy && !strb && (color !== last_col)) color_err = 1'b1;
      if (strb) begin
        if (idle_cnt < 3) gap_err = 1'b1;
        got_col.push_back(color);
        last_col = color;
        n_strb++;
      end
      if (rst_strb) n_rst++;
      if (drop) n_drop++;
      if (drv_busy) idle_cnt = 0;
      else if (idle_cnt < 1000) idle_cnt++;
    end else begin
      last_col = '0;
      idle_cnt = 1000;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] col_at(input int k);
    if (got_col.size() > k) return got_col[k];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clear_mon();
    n_strb = 0; n_rst = 0; n_drop = 0;
    got_col.delete();
  endtask

  task automatic write_pix(input logic [2:0] idx, input logic [31:0] col);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_color = col;
    @(negedge clk);
    wr_en = 1'b0;
    mem_model[idx] = col;
  endtask

  task automatic pulse_start(input logic [3:0] na);
    @(negedge clk);
    num_active = na; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    last_cycles = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      last_cycles++;
      if (done) begin seen = 1'b1; busy_at_done = busy; end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_strobes(input int n, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); #1;
      if (n_strb >= n) ok = 1'b1;
    end
    check({name, " strobe reached"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [3:0]  num_active;
    int unsigned exp_strb;
  } frame_vec_t;
  frame_vec_t vecs[5];

  logic [31:0] exp0, exp1;
  logic [31:0] q6[$];
  bit seen6;

  initial begin
    vecs[0] = '{4'd3,  3};
    vecs[1] = '{4'd0,  0};
    vecs[2] = '{4'd15, 8};
    vecs[3] = '{4'd1,  1};
    vecs[4] = '{4'd8,  8};

    repeat (3) @(negedge clk);
    check("reset ctrl", {27'b0, busy, done, drop, strb, rst_strb}, 32'h0);
    check("reset color", color, 32'h0);
    rst_n = 1'b1;

    write_pix(3'd0, 32'h1122_3344);
    write_pix(3'd1, 32'h5566_7788);
    write_pix(3'd2, 32'h99AA_BBCC);
    for (int unsigned i = 3; i < 8; i++) write_pix(3'(i), 32'h0A0B_0C00 | i);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      pulse_start(vecs[v].num_active);
      wait_done($sformatf("vec%0d", v));
      check($sformatf("vec%0d strobes", v), 32'(n_strb), vecs[v].exp_strb);
      for (int k = 0; k < int'(vecs[v].exp_strb); k++)
        check($sformatf("vec%0d color%0d", v, k), col_at(k), mem_model[k]);
      check($sformatf("vec%0d latches", v), 32'(n_rst), 32'd1);
      check($sformatf("vec%0d busy at done", v), 32'(busy_at_done), 32'd0);
      check($sformatf("vec%0d drops", v), 32'(n_drop), 32'd0);
      check($sformatf("vec%0d length", v),
            32'(last_cycles >= 100 + 40 * int'(vecs[v].exp_strb)), 32'd1);
    end

    // Start latency and first-strobe timing.
    clear_mon();
    @(negedge clk);
    check("t6 busy before", 32'(busy), 32'd0);
    num_active = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6 busy t+1", 32'(busy), 32'd1);
    check("t6 strb t+1", 32'(strb), 32'd0);
    @(negedge clk);
    check("t6 strb t+2", 32'(strb), 32'd0);
    @(negedge clk);
    check("t6 strb t+3", 32'(strb), 32'd1);
    check("t6 color t+3", color, mem_model[0]);
    wait_done("t6");
    check("t6 strobes", 32'(n_strb), 32'd2);
    check("t6 color held", color, mem_model[1]);

    // Mid-frame start and writes.
    clear_mon();
    exp0 = mem_model[0];
    exp1 = mem_model[1];
    pulse_start(4'd3);
    wait_strobes(1, "t4");
    repeat (2) @(negedge clk);
    write_pix(3'd2, 32'hDEAD_BEEF);
    write_pix(3'd0, 32'h0BAD_F00D);
    pulse_start(4'd3);
    wait_done("t4");
    check("t4 strobes", 32'(n_strb), 32'd3);
    check("t4 fetched pixel0", col_at(0), exp0);
    check("t4 pixel1", col_at(1), exp1);
    check("t4 late write pixel2", col_at(2), 32'hDEAD_BEEF);
    check("t4 drops", 32'(n_drop), 32'd1);

    // Asynchronous reset during the wait on pixel 1.
    clear_mon();
    pulse_start(4'd3);
    wait_strobes(2, "t5");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 reset ctrl", {27'b0, busy, done, drop, strb, rst_strb}, 32'h0);
    check("t5 reset color", color, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    pulse_start(4'd2);
    wait_done("t5 restart");
    check("t5 strobes", 32'(n_strb), 32'd2);
    check("t5 color0", col_at(0), 32'h0BAD_F00D);
    check("t5 color1", col_at(1), 32'h5566_7788);
    check("t5 latches", 32'(n_rst), 32'd1);

    check("strb/latch overlap", 32'(overlap_err), 32'd0);
    check("color stable while busy", 32'(color_err), 32'd0);
    check("idle gap >= 3", 32'(gap_err), 32'd0);

    // Six-pixel instance: clamp to a non-power-of-two depth, out-of-range writes dropped.
    for (int unsigned i = 0; i < 6; i++) write_pix(3'(i), 32'h6000_0000 + i);
    write_pix(3'd6, 32'hFFFF_FFFF);
    write_pix(3'd7, 32'hEEEE_EEEE);
    @(negedge clk);
    num_active = 4'd15; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    seen6 = 1'b0;
    for (int i = 0; i < 3000 && !seen6; i++) begin
      @(negedge clk);
      if (strb6) q6.push_back(color6);
      if (done6) seen6 = 1'b1;
    end
    check("d6 done seen", 32'(seen6), 32'd1);
    check("d6 strobes", 32'(q6.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("d6 color%0d", k),
            (q6.size() > k) ? q6[k] : 32'hxxxx_xxxx, 32'h6000_0000 + k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
